// File: rtl/k6502_bus_pkg.sv
// Shared types and constants for the k6502 bus responder.
package k6502_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } bus_resp_state_t;

    localparam logic [15:0] RESET_VEC_LO = 16'hFFFC;
    localparam logic [15:0] RESET_VEC_HI = 16'hFFFD;

endpackage

// File: rtl/responder_ram.sv
// Single-port byte RAM with registered read; contents are not reset.
module responder_ram #(
    parameter int unsigned ADDR_W = 11
) (
    input  logic              ph0,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge ph0) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/bus_responder.sv
// Memory-side responder for the k6502 CPU bus: mirrored RAM window with wait states.
// Optional feature: define RESET_VECTOR_EN to serve RESET_VECTOR at $FFFC/$FFFD.
module bus_responder
    import k6502_bus_pkg::*;
#(
    parameter logic [15:0] BASE         = 16'h0000,
    parameter int unsigned DECODE_W     = 13,
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned WAIT_STATES  = 0,
    parameter logic [15:0] RESET_VECTOR = 16'hC000
) (
    input  logic        ph0,
    input  logic        reset,
    input  logic        cyc,
    input  logic [15:0] addr,
    input  logic        rw,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        rdata_oe,
    output logic        ack,
    output logic        busy
);

    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    bus_resp_state_t   state, next_state;
    logic [3:0]        cnt, cnt_next;
    logic [ADDR_W-1:0] addr_l;
    logic              rw_l;
    logic [7:0]        wdata_l;
    logic              vec_l;

    logic              win_hit, vec_hit, accept, enter_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata, ram_q;
    logic              rw_e, vec_e, ram_we;
    logic              vec_sel;
    logic [7:0]        vec_byte;

    // Shift-based compare stays legal for DECODE_W == 16 (whole space is the window).
    assign win_hit = (((addr ^ BASE) >> DECODE_W) == 16'h0000);

`ifdef RESET_VECTOR_EN
    assign vec_hit = (addr == RESET_VEC_LO) || (addr == RESET_VEC_HI);
`else
    assign vec_hit = 1'b0;
`endif

    assign accept = (state == IDLE) && cyc && (win_hit || vec_hit);

    // With no wait states the accept edge is also the ACK-entry edge, so the
    // RAM must see the live bus in IDLE and the latched request otherwise.
    assign ram_addr  = (state == IDLE) ? addr[ADDR_W-1:0] : addr_l;
    assign ram_wdata = (state == IDLE) ? wdata : wdata_l;
    assign rw_e      = (state == IDLE) ? rw : rw_l;
    assign vec_e     = (state == IDLE) ? vec_hit : vec_l;

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        next_state = WAIT;
                        cnt_next   = WS_LOAD;
                    end else begin
                        next_state = ACK;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = ACK;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign enter_ack = (next_state == ACK) && (state != ACK);
    assign ram_we    = enter_ack && !rw_e && !vec_e && !reset;

    always_ff @(posedge ph0) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge ph0) begin
        if (reset) begin
            ack      <= 1'b0;
            busy     <= 1'b0;
            rdata_oe <= 1'b0;
            vec_sel  <= 1'b0;
            vec_byte <= '0;
        end else begin
            ack      <= (next_state == ACK);
            busy     <= (next_state != IDLE);
            rdata_oe <= enter_ack && rw_e;
            if (enter_ack) begin
                vec_sel  <= vec_e;
                vec_byte <= ram_addr[0] ? RESET_VECTOR[15:8] : RESET_VECTOR[7:0];
            end
        end
    end

    always_ff @(posedge ph0) begin
        if (accept) begin
            addr_l  <= addr[ADDR_W-1:0];
            rw_l    <= rw;
            wdata_l <= wdata;
            vec_l   <= vec_hit;
        end
    end

    assign rdata = rdata_oe ? (vec_sel ? vec_byte : ram_q) : '0;

    responder_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .ph0  (ph0),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_q)
    );

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: a zero-wait and a three-wait instance sharing one bus.
module tb_bus_responder;

`ifdef RESET_VECTOR_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif

    logic        ph0 = 1'b0;
    logic        reset, cyc0, cyc3, rw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata0, rdata3;
    logic        oe0, oe3, ack0, ack3, busy0, busy3;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        bit          use3;
        logic [15:0] a;
        bit          rd;
        logic [7:0]  wd;
        bit          exp_ack;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t tbl[$];

    always #5 ph0 = ~ph0;

    bus_responder #(
        .BASE(16'h0000), .DECODE_W(13), .ADDR_W(11),
        .WAIT_STATES(0), .RESET_VECTOR(16'hC004)
    ) dut0 (
        .ph0(ph0), .reset(reset), .cyc(cyc0), .addr(addr), .rw(rw), .wdata(wdata),
        .rdata(rdata0), .rdata_oe(oe0), .ack(ack0), .busy(busy0)
    );

    bus_responder #(
        .BASE(16'h0000), .DECODE_W(13), .ADDR_W(11),
        .WAIT_STATES(3), .RESET_VECTOR(16'hC004)
    ) dut3 (
        .ph0(ph0), .reset(reset), .cyc(cyc3), .addr(addr), .rw(rw), .wdata(wdata),
        .rdata(rdata3), .rdata_oe(oe3), .ack(ack3), .busy(busy3)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge ph0);
        @(negedge ph0);
    endtask

    task automatic access(input vec_t v);
        int         ws;
        bit         got, seen_busy, pushed;
        logic       a, b, o;
        logic [7:0] d;
        ws        = v.use3 ? 3 : 0;
        got       = 1'b0;
        seen_busy = 1'b0;
        pushed    = 1'b0;
        addr  = v.a;
        rw    = v.rd;
        wdata = v.wd;
        if (v.use3) cyc3 = 1'b1; else cyc0 = 1'b1;
        if (v.rd && v.exp_ack) begin
            exp_q.push_back(v.exp_rd);
            pushed = 1'b1;
        end
        for (int i = 1; i <= 20 && !got; i++) begin
            cycle();
            a = v.use3 ? ack3 : ack0;
            b = v.use3 ? busy3 : busy0;
            o = v.use3 ? oe3 : oe0;
            d = v.use3 ? rdata3 : rdata0;
            if (b) seen_busy = 1'b1;
            if (a) begin
                got = 1'b1;
                cyc0 = 1'b0;
                cyc3 = 1'b0;
                chk("latency", i, 1 + ws);
                chk("rdata_oe", int'(o), int'(v.rd));
                if (v.rd && exp_q.size() > 0) begin
                    chk("rdata", int'(d), int'(exp_q.pop_front()));
                    pushed = 1'b0;
                end else begin
                    chk("rdata_nodrive", int'(d), 0);
                end
            end
        end
        cyc0 = 1'b0;
        cyc3 = 1'b0;
        chk("acked", int'(got), int'(v.exp_ack));
        if (!v.exp_ack) chk("busy_on_miss", int'(seen_busy), 0);
        if (pushed) void'(exp_q.pop_back());
        cycle();
        a = v.use3 ? ack3 : ack0;
        o = v.use3 ? oe3 : oe0;
        chk("ack_one_cycle", int'(a), 0);
        chk("oe_one_cycle", int'(o), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cyc0  = 1'b0;
        cyc3  = 1'b0;
        rw    = 1'b1;
        addr  = '0;
        wdata = '0;
        @(negedge ph0);
        cycle();
        cycle();
        chk("rst_ack0", int'(ack0), 0);
        chk("rst_busy0", int'(busy0), 0);
        chk("rst_oe0", int'(oe0), 0);
        chk("rst_rdata0", int'(rdata0), 0);
        chk("rst_ack3", int'(ack3), 0);
        chk("rst_busy3", int'(busy3), 0);
        reset = 1'b0;
        cycle();

        //            use3  addr      rd    wdata  ack   expected read
        tbl.push_back('{1'b0, 16'h0042, 1'b0, 8'hA5, 1'b1, 8'h00});
        tbl.push_back('{1'b0, 16'h0042, 1'b1, 8'h00, 1'b1, 8'hA5});
        tbl.push_back('{1'b0, 16'h0010, 1'b0, 8'h3C, 1'b1, 8'h00});
        tbl.push_back('{1'b0, 16'h0810, 1'b1, 8'h00, 1'b1, 8'h3C});
        tbl.push_back('{1'b0, 16'h1810, 1'b1, 8'h00, 1'b1, 8'h3C});
        tbl.push_back('{1'b0, 16'h2010, 1'b1, 8'h00, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 16'h07FF, 1'b0, 8'h5A, 1'b1, 8'h00});
        tbl.push_back('{1'b0, 16'h1FFF, 1'b1, 8'h00, 1'b1, 8'h5A});
        tbl.push_back('{1'b0, 16'h07FC, 1'b0, 8'h66, 1'b1, 8'h00});
        tbl.push_back('{1'b0, 16'hFFFC, 1'b1, 8'h00, VEC,  8'h04});
        tbl.push_back('{1'b0, 16'hFFFD, 1'b1, 8'h00, VEC,  8'hC0});
        tbl.push_back('{1'b0, 16'hFFFC, 1'b0, 8'h99, VEC,  8'h00});
        tbl.push_back('{1'b0, 16'hFFFC, 1'b1, 8'h00, VEC,  8'h04});
        tbl.push_back('{1'b0, 16'h07FC, 1'b1, 8'h00, 1'b1, 8'h66});
        tbl.push_back('{1'b1, 16'h0005, 1'b0, 8'h11, 1'b1, 8'h00});
        tbl.push_back('{1'b1, 16'h0005, 1'b1, 8'h00, 1'b1, 8'h11});

        foreach (tbl[k]) access(tbl[k]);

        // Three-wait read with address/data churn while waiting.
        addr = 16'h0005;
        rw   = 1'b1;
        cyc3 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            chk("ws_busy", int'(busy3), 1);
            chk("ws_ack", int'(ack3), (k == 4) ? 1 : 0);
            if (k < 4) begin
                addr  = 16'($urandom_range(0, 16'h07FF));
                wdata = 8'($urandom);
            end else begin
                chk("ws_rdata", int'(rdata3), 8'h11);
                cyc3 = 1'b0;
            end
        end
        cycle();
        chk("ws_idle_busy", int'(busy3), 0);

        // Three-wait write: only the accept-edge data may land.
        addr  = 16'h0006;
        rw    = 1'b0;
        wdata = 8'h22;
        cyc3  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cycle();
            if (k < 4) wdata = 8'($urandom) | 8'h80;
            if (ack3) cyc3 = 1'b0;
        end
        cyc3 = 1'b0;
        cycle();
        access('{1'b1, 16'h0006, 1'b1, 8'h00, 1'b1, 8'h22});

        // Reset during WAIT aborts a pending write.
        addr  = 16'h0005;
        rw    = 1'b0;
        wdata = 8'h77;
        cyc3  = 1'b1;
        cycle();
        cyc3 = 1'b0;
        chk("abort_busy_pre", int'(busy3), 1);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("abort_busy", int'(busy3), 0);
        chk("abort_ack", int'(ack3), 0);
        begin
            bit late_ack;
            late_ack = 1'b0;
            for (int k = 0; k < 6; k++) begin
                cycle();
                if (ack3 || busy3) late_ack = 1'b1;
            end
            chk("abort_no_ack", int'(late_ack), 0);
        end
        access('{1'b1, 16'h0005, 1'b1, 8'h00, 1'b1, 8'h11});

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
